// File: rtl/axi4lite_master.sv
// AXI4-Lite initiator: turns single-beat command-port requests into AXI4-Lite
// transactions, one outstanding at a time, returning one response per command.
module axi4lite_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                        A_CLK,
  input  logic                        A_RST,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_write,
  output logic [7:0]                  err_count,
  output logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR,
  output logic                        AW_VALID,
  input  logic                        AW_READY,
  output logic [AXI_DATA_WIDTH-1:0]   W_DATA,
  output logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
  output logic                        W_VALID,
  input  logic                        W_READY,
  input  logic [1:0]                  B_RESP,
  input  logic                        B_VALID,
  output logic                        B_READY,
  output logic [AXI_ADDR_WIDTH-1:0]   AR_ADDR,
  output logic                        AR_VALID,
  input  logic                        AR_READY,
  input  logic [AXI_DATA_WIDTH-1:0]   R_DATA,
  input  logic [1:0]                  R_RESP,
  input  logic                        R_VALID,
  output logic                        R_READY
);

  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4,
    S_RSP     = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      aw_valid_q, aw_valid_d;
  logic                      w_valid_q, w_valid_d;
  logic                      b_ready_q, b_ready_d;
  logic                      ar_valid_q, ar_valid_d;
  logic                      r_ready_q, r_ready_d;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0]     w_strb_q, w_strb_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic                      rsp_write_q, rsp_write_d;
  logic [7:0]                err_count_q, err_count_d;
  logic                      err_inc;

  // Next-state and next-output logic; every AXI output is derived from registered state only.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    b_ready_d   = b_ready_q;
    ar_valid_d  = ar_valid_q;
    r_ready_d   = r_ready_q;
    aw_addr_d   = aw_addr_q;
    ar_addr_d   = ar_addr_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_write_d = rsp_write_q;
    err_inc     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          if (cmd_write) begin
            state_d    = S_WR;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_addr_d  = cmd_addr;
            w_data_d   = cmd_wdata;
            w_strb_d   = cmd_wstrb;
          end else begin
            state_d    = S_RD_ADDR;
            ar_valid_d = 1'b1;
            ar_addr_d  = cmd_addr;
          end
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      S_WR: begin
        // AW and W retire independently; each clears its payload once accepted.
        if (aw_valid_q && AW_READY) begin
          aw_valid_d = 1'b0;
          aw_addr_d  = {AXI_ADDR_WIDTH{1'b0}};
          aw_done_d  = 1'b1;
        end else begin
          aw_valid_d = aw_valid_q;
        end
        if (w_valid_q && W_READY) begin
          w_valid_d = 1'b0;
          w_data_d  = {AXI_DATA_WIDTH{1'b0}};
          w_strb_d  = {STRB_WIDTH{1'b0}};
          w_done_d  = 1'b1;
        end else begin
          w_valid_d = w_valid_q;
        end
        if (aw_done_d && w_done_d) begin
          state_d   = S_WR_RESP;
          b_ready_d = 1'b1;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR_RESP: begin
        if (B_VALID && b_ready_q) begin
          b_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = B_RESP;
          rsp_rdata_d = {AXI_DATA_WIDTH{1'b0}};
          rsp_write_d = 1'b1;
          err_inc     = (B_RESP != 2'b00);
          state_d     = S_RSP;
        end else begin
          b_ready_d = 1'b1;
        end
      end
      S_RD_ADDR: begin
        if (ar_valid_q && AR_READY) begin
          ar_valid_d = 1'b0;
          ar_addr_d  = {AXI_ADDR_WIDTH{1'b0}};
          r_ready_d  = 1'b1;
          state_d    = S_RD_DATA;
        end else begin
          ar_valid_d = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (R_VALID && r_ready_q) begin
          r_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = R_RESP;
          rsp_rdata_d = R_DATA;
          rsp_write_d = 1'b0;
          err_inc     = (R_RESP != 2'b00);
          state_d     = S_RSP;
        end else begin
          r_ready_d = 1'b1;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        aw_valid_d  = 1'b0;
        w_valid_d   = 1'b0;
        b_ready_d   = 1'b0;
        ar_valid_d  = 1'b0;
        r_ready_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase

    err_count_d = (err_inc && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_addr_q   <= {AXI_ADDR_WIDTH{1'b0}};
      ar_addr_q   <= {AXI_ADDR_WIDTH{1'b0}};
      w_data_q    <= {AXI_DATA_WIDTH{1'b0}};
      w_strb_q    <= {STRB_WIDTH{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {AXI_DATA_WIDTH{1'b0}};
      rsp_resp_q  <= 2'b00;
      rsp_write_q <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      b_ready_q   <= b_ready_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      aw_addr_q   <= aw_addr_d;
      ar_addr_q   <= ar_addr_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_write_q <= rsp_write_d;
      err_count_q <= err_count_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_write = rsp_write_q;
  assign err_count = err_count_q;
  assign AW_ADDR   = aw_addr_q;
  assign AW_VALID  = aw_valid_q;
  assign W_DATA    = w_data_q;
  assign W_STRB    = w_strb_q;
  assign W_VALID   = w_valid_q;
  assign B_READY   = b_ready_q;
  assign AR_ADDR   = ar_addr_q;
  assign AR_VALID  = ar_valid_q;
  assign R_READY   = r_ready_q;

endmodule

// File: tb/tb_axi4lite_master.sv
// Scoreboard bench for axi4lite_master: a behavioural AXI4-Lite slave with
// programmable AW/W stalls and response codes, plus a response monitor.
`timescale 1ns/1ps
module tb_axi4lite_master;

  typedef struct packed {
    logic        w;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } rsp_t;

  logic        A_CLK = 1'b0;
  logic        A_RST = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'd0, cmd_wdata = 32'd0;
  logic [3:0]  cmd_wstrb = 4'd0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [7:0]  err_count;
  logic [31:0] AW_ADDR, W_DATA, AR_ADDR;
  logic [3:0]  W_STRB;
  logic        AW_VALID, W_VALID, AR_VALID, B_READY, R_READY;
  logic        AW_READY = 1'b0, W_READY = 1'b0, AR_READY = 1'b0;
  logic        B_VALID = 1'b0, R_VALID = 1'b0;
  logic [1:0]  B_RESP = 2'b00, R_RESP = 2'b00;
  logic [31:0] R_DATA = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;
  rsp_t exp_q[$];
  rsp_t got_q[$];

  // slave configuration (written by the test sequence only)
  int         aw_delay = 0, w_delay = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  // slave observations (written by the slave process only)
  int aw_vcyc = 0, w_vcyc = 0, b_acc = 0;

  axi4lite_master #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
    .A_CLK(A_CLK), .A_RST(A_RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write), .err_count(err_count),
    .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
    .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
    .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
    .AR_ADDR(AR_ADDR), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
    .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY)
  );

  always #5 A_CLK = ~A_CLK;

  // Behavioural slave: decides READY/VALID at the falling edge for the next rising edge.
  initial begin : slave
    logic [31:0] mem [0:255];
    logic [31:0] aw_a, w_d, ar_a;
    logic [3:0]  w_s;
    int  aw_cnt, w_cnt;
    bit  aw_ok, w_ok, ar_ok, b_fire, r_fire;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    aw_cnt = 0; w_cnt = 0; aw_ok = 0; w_ok = 0; ar_ok = 0; b_fire = 0; r_fire = 0;
    aw_a = 32'd0; w_d = 32'd0; ar_a = 32'd0; w_s = 4'd0;
    forever begin
      @(negedge A_CLK);
      if (A_RST) begin
        AW_READY = 1'b0; W_READY = 1'b0; AR_READY = 1'b0; B_VALID = 1'b0; R_VALID = 1'b0;
        aw_cnt = 0; w_cnt = 0; aw_ok = 0; w_ok = 0; ar_ok = 0; b_fire = 0; r_fire = 0;
      end else begin
        if (b_fire) begin B_VALID = 1'b0; b_fire = 0; end
        if (!B_VALID && aw_ok && w_ok) begin
          for (int i = 0; i < 4; i++) if (w_s[i]) mem[aw_a[9:2]][8*i +: 8] = w_d[8*i +: 8];
          B_VALID = 1'b1; B_RESP = bresp_cfg; aw_ok = 0; w_ok = 0;
        end
        if (B_VALID && B_READY) begin b_fire = 1; b_acc++; end
        AW_READY = 1'b0;
        if (AW_VALID) begin
          aw_vcyc++;
          if (aw_cnt >= aw_delay) begin AW_READY = 1'b1; aw_ok = 1; aw_a = AW_ADDR; aw_cnt = 0; end
          else aw_cnt++;
        end else aw_cnt = 0;
        W_READY = 1'b0;
        if (W_VALID) begin
          w_vcyc++;
          if (w_cnt >= w_delay) begin W_READY = 1'b1; w_ok = 1; w_d = W_DATA; w_s = W_STRB; w_cnt = 0; end
          else w_cnt++;
        end else w_cnt = 0;
        if (r_fire) begin R_VALID = 1'b0; r_fire = 0; end
        if (!R_VALID && ar_ok) begin
          R_VALID = 1'b1; R_DATA = mem[ar_a[9:2]]; R_RESP = rresp_cfg; ar_ok = 0;
        end
        if (R_VALID && R_READY) r_fire = 1;
        AR_READY = 1'b0;
        if (AR_VALID) begin AR_READY = 1'b1; ar_ok = 1; ar_a = AR_ADDR; end
      end
    end
  end

  // Response monitor: records each response that will complete at the next rising edge.
  initial begin : monitor
    rsp_t r;
    forever begin
      @(negedge A_CLK);
      if (!A_RST && rsp_valid && rsp_ready) begin
        r.w = rsp_write; r.resp = rsp_resp; r.rdata = rsp_rdata;
        got_q.push_back(r);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge A_CLK);
    #1;
  endtask

  // Drive one command, wait for acceptance and record the expected response.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit push, input logic [1:0] eresp,
                       input logic [31:0] erdata);
    rsp_t e;
    int t;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    t = 0;
    while (!cmd_ready && t < 50) begin tick(); t++; end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept_timeout actual cmd_ready=0 required=1");
    end
    tick();
    cmd_valid = 1'b0; cmd_wdata = 32'd0; cmd_wstrb = 4'd0;
    if (push) begin
      e.w = w; e.resp = eresp; e.rdata = erdata;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_rsp(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 100) begin tick(); t++; end
    if (got_q.size() < n) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_timeout actual=%0d responses required=%0d", got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    A_RST = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({AW_VALID, W_VALID, B_READY, AR_VALID, R_READY, rsp_valid} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_handshakes actual=%b required=000000",
               {AW_VALID, W_VALID, B_READY, AR_VALID, R_READY, rsp_valid});
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready actual=%b required=1", cmd_ready); end
    n_checks++;
    if ({rsp_write, rsp_resp, rsp_rdata} !== 35'd0) begin
      n_fail++; $display("FAIL reset_rsp actual=%h required=0", {rsp_write, rsp_resp, rsp_rdata});
    end
    n_checks++;
    if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count actual=%0d required=0", err_count); end
    n_checks++;
    if ({AW_ADDR, W_DATA, W_STRB, AR_ADDR} !== 100'd0) begin
      n_fail++; $display("FAIL reset_addr_data actual=%h required=0", {AW_ADDR, W_DATA, W_STRB, AR_ADDR});
    end
    A_RST = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    rsp_t e, g;
    rsp_ready = 1'b1;
    issue(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 1'b1, 2'b00, 32'd0);
    issue(1'b0, 32'h4, 32'd0, 4'h0, 1'b1, 2'b00, 32'hDEADBEEF);
    wait_rsp(2);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL write_read_rsp actual=%h required=%h", g, e); end
    end
    n_checks++;
    if (err_count !== 8'd0) begin n_fail++; $display("FAIL write_read_err actual=%0d required=0", err_count); end
  endtask

  task automatic test_latency();
    rsp_t e, g;
    int n;
    rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) issue(1'b1, 32'h8, 32'h12345678, 4'hF, 1'b1, 2'b00, 32'd0);
      else        issue(1'b0, 32'h8, 32'd0, 4'h0, 1'b1, 2'b00, 32'h12345678);
      n = 1;
      while (!rsp_valid && n < 10) begin
        n_checks++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL latency_cmd_ready cycle=%0d actual=%b required=0", n, cmd_ready); end
        tick(); n++;
      end
      n_checks++;
      if (n != 3) begin n_fail++; $display("FAIL latency_rsp_cycle kind=%0d actual=%0d required=3", k, n); end
      tick();
      n_checks++;
      if ({cmd_ready, rsp_valid} !== 2'b10) begin
        n_fail++; $display("FAIL latency_complete actual=%b required=10", {cmd_ready, rsp_valid});
      end
      wait_rsp(1);
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL latency_rsp actual=%h required=%h", g, e); end
      end
    end
  endtask

  task automatic test_wr_skew();
    rsp_t e, g;
    int ad [3] = '{3, 0, 2};
    int wd [3] = '{0, 3, 2};
    int aw0, w0, b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      aw_delay = ad[k]; w_delay = wd[k];
      aw0 = aw_vcyc; w0 = w_vcyc; b0 = b_acc;
      issue(1'b1, 32'h40 + 32'(k * 4), 32'hA5A50000 + 32'(k), 4'hF, 1'b1, 2'b00, 32'd0);
      wait_rsp(1);
      tick();
      n_checks++;
      if (aw_vcyc - aw0 != ad[k] + 1) begin n_fail++; $display("FAIL skew_aw_cycles cfg=%0d actual=%0d required=%0d", k, aw_vcyc - aw0, ad[k] + 1); end
      n_checks++;
      if (w_vcyc - w0 != wd[k] + 1) begin n_fail++; $display("FAIL skew_w_cycles cfg=%0d actual=%0d required=%0d", k, w_vcyc - w0, wd[k] + 1); end
      n_checks++;
      if (b_acc - b0 != 1) begin n_fail++; $display("FAIL skew_b_count cfg=%0d actual=%0d required=1", k, b_acc - b0); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL skew_rsp actual=%h required=%h", g, e); end
      end
    end
    aw_delay = 0; w_delay = 0;
  endtask

  task automatic test_backpressure();
    rsp_t e, g;
    int t;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h4, 32'd0, 4'h0, 1'b1, 2'b00, 32'hDEADBEEF);
    t = 0;
    while (!rsp_valid && t < 20) begin tick(); t++; end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({rsp_valid, rsp_resp, rsp_rdata} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin
        n_fail++; $display("FAIL bp_rsp_stable cycle=%0d actual=%h required=%h", c, {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'hDEADBEEF});
      end
      n_checks++;
      if ({cmd_ready, AW_VALID, W_VALID, AR_VALID} !== 4'b0000) begin
        n_fail++; $display("FAIL bp_idle_bus cycle=%0d actual=%b required=0000", c, {cmd_ready, AW_VALID, W_VALID, AR_VALID});
      end
      tick();
    end
    rsp_ready = 1'b1;
    n_checks++;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_still_valid actual=%b required=1", rsp_valid); end
    tick();
    n_checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_complete actual=%b required=01", {rsp_valid, cmd_ready});
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL bp_rsp actual=%h required=%h", g, e); end
    end
  endtask

  task automatic test_err_sat();
    rsp_t e, g;
    rsp_ready = 1'b1;
    rresp_cfg = 2'b10;
    for (int i = 0; i < 300; i++) begin
      issue(1'b0, 32'h100, 32'd0, 4'h0, 1'b1, 2'b10, 32'd0);
      wait_rsp(1);
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL err_rsp idx=%0d actual=%h required=%h", i, g, e); end
      end
      if (i == 99 || i == 254 || i == 255 || i == 299) begin
        n_checks++;
        if (err_count !== ((i < 255) ? 8'(i + 1) : 8'd255)) begin
          n_fail++; $display("FAIL err_count idx=%0d actual=%0d required=%0d", i, err_count, (i < 255) ? i + 1 : 255);
        end
      end
    end
    rresp_cfg = 2'b00;
    issue(1'b1, 32'h100, 32'd0, 4'hF, 1'b1, 2'b00, 32'd0);
    wait_rsp(1);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL err_okay_rsp actual=%h required=%h", g, e); end
    end
    n_checks++;
    if (err_count !== 8'd255) begin n_fail++; $display("FAIL err_hold actual=%0d required=255", err_count); end
  endtask

  task automatic test_reset_mid();
    rsp_t e, g;
    rsp_ready = 1'b1;
    aw_delay = 10; w_delay = 10;
    issue(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, 2'b00, 32'd0);
    tick();
    n_checks++;
    if ({AW_VALID, W_VALID} !== 2'b11) begin n_fail++; $display("FAIL mid_pending actual=%b required=11", {AW_VALID, W_VALID}); end
    A_RST = 1'b1;
    tick();
    A_RST = 1'b0;
    aw_delay = 0; w_delay = 0;
    n_checks++;
    if ({AW_VALID, W_VALID, B_READY, AR_VALID, R_READY, rsp_valid} !== 6'b000000) begin
      n_fail++; $display("FAIL mid_handshakes actual=%b required=000000", {AW_VALID, W_VALID, B_READY, AR_VALID, R_READY, rsp_valid});
    end
    n_checks++;
    if ({cmd_ready, err_count} !== {1'b1, 8'd0}) begin
      n_fail++; $display("FAIL mid_ready_err actual=%b/%0d required=1/0", cmd_ready, err_count);
    end
    repeat (4) tick();
    n_checks++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL mid_no_rsp actual=%0d required=0", got_q.size()); end
    issue(1'b0, 32'h4, 32'd0, 4'h0, 1'b1, 2'b00, 32'hDEADBEEF);
    wait_rsp(1);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL mid_read_rsp actual=%h required=%h", g, e); end
    end
  endtask

  initial begin : main
    test_reset();
    test_write_read();
    test_latency();
    test_wr_skew();
    test_backpressure();
    test_err_sat();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0 || got_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_leftover actual=%0d/%0d required=0/0", exp_q.size(), got_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
